// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and sizing helpers for the serial adder.
// Imported by the interface, the full-adder cell and the sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int DEF_WIDTH = 4;

  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: request/result bundle of the serial adder.
// ovf exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, ci,
    input  busy, done, s, co, ovf
  );

  modport slave (
    input  start, a, b, ci,
    output busy, done, s, co, ovf
  );
`else
  modport master (
    output start, a, b, ci,
    input  busy, done, s, co
  );

  modport slave (
    input  start, a, b, ci,
    output busy, done, s, co
  );
`endif

endinterface

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: one full adder plus the carry register it feeds back.
// The carry loads ci on accept and follows the cell carry-out while running.
module serial_fa_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  input  logic ci,
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);

  logic carry;

  assign s  = a ^ b ^ carry;
  assign co = (a & b) | (carry & (a ^ b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry <= 1'b0;
    end else if (load) begin
      carry <= ci;
    end else if (en) begin
      carry <= co;
    end
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder sequencer sharing one full-adder cell.
// Define SERIAL_ADD_OVF_EN to add the registered two's-complement ovf output.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic              clk,
  input logic              rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state;
  state_t           nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-2:0] sr;
  logic [WIDTH-1:0] sum_n;
  logic [WIDTH-1:0] s_q;
  logic             co_q;
  logic             fa_s;
  logic             fa_co;
  logic             run;
  logic             accept;
  logic             last;

  assign run    = (state == RUN);
  assign accept = bus.start && (state != RUN);
  assign last   = run && (cnt == CW'(WIDTH - 1));
  assign sum_n  = {fa_s, sr};

  serial_fa_cell u_fa (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .en    (run),
    .ci    (bus.ci),
    .a     (sa[0]),
    .b     (sb[0]),
    .s     (fa_s),
    .co    (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (1'b1)
      (state == IDLE): if (bus.start) nxt = RUN;
      (state == RUN):  if (last) nxt = DONE;
      (state == DONE): nxt = bus.start ? RUN : IDLE;
      default:         nxt = IDLE;
    endcase
  end

  // sr keeps only the upper sum bits; the MSB arrives on the last cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      sr  <= '0;
      cnt <= '0;
    end else if (accept) begin
      sa  <= bus.a;
      sb  <= bus.b;
      cnt <= '0;
    end else if (run) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      sr  <= sum_n[WIDTH-1:1];
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q  <= '0;
      co_q <= 1'b0;
    end else if (last) begin
      s_q  <= sum_n;
      co_q <= fa_co;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  // carry into the MSB is recovered as s ^ a ^ b of the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (last) begin
      ovf_q <= fa_s ^ sa[0] ^ sb[0] ^ fa_co;
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.busy = run;
  assign bus.done = (state == DONE);
  assign bus.s    = s_q;
  assign bus.co   = co_q;

endmodule
